// File: rtl/td4_core.sv
// td4_core: single-cycle TD4 core holding PC, A, B, carry and the output latch.
module td4_core #(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [3:0] IN,
  output logic [3:0] ROM_A,
  input  logic [7:0] ROM_D,
  output logic [3:0] OUT,
  output logic       CARRY,
  output logic [3:0] REG_A,
  output logic [3:0] REG_B
);
  logic [3:0] pc_q, pc_d, a_q, a_d, b_q, b_d, out_q, out_d;
  logic       c_q, c_d;
  logic [3:0] op, im;
  logic [4:0] sum_a, sum_b;
  assign op    = ROM_D[7:4];
  assign im    = ROM_D[3:0];
  assign sum_a = {1'b0, a_q} + {1'b0, im};
  assign sum_b = {1'b0, b_q} + {1'b0, im};
  always_comb begin
    a_d   = op == 4'h0 ? sum_a[3:0] :
            op == 4'h1 ? b_q :
            op == 4'h2 ? IN :
            op == 4'h3 ? im : a_q;
    b_d   = op == 4'h4 ? a_q :
            op == 4'h5 ? sum_b[3:0] :
            op == 4'h6 ? IN :
            op == 4'h7 ? im : b_q;
    c_d   = op == 4'h0 ? sum_a[4] :
            op == 4'h5 ? sum_b[4] : 1'b0;
    out_d = op == 4'h9 ? b_q :
            op == 4'hB ? im : out_q;
    // JNC tests the carry held from the previous instruction
    pc_d  = (op == 4'hF || (op == 4'hE && !c_q)) ? im : pc_q + 4'h1;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q  <= RESET_PC;
      a_q   <= 4'h0;
      b_q   <= 4'h0;
      c_q   <= 1'b0;
      out_q <= 4'h0;
    end else if (EN) begin
      pc_q  <= pc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      out_q <= out_d;
    end
  end
  assign ROM_A = pc_q;
  assign OUT   = out_q;
  assign CARRY = c_q;
  assign REG_A = a_q;
  assign REG_B = b_q;
endmodule

// File: tb/tb_td4_core.sv
// tb_td4_core: directed programs against an instruction-level model of the TD4.
module tb_td4_core;
  logic       clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [3:0] in_p = 4'h0;
  logic [3:0] rom_a, rom_a8, out_p, out8, reg_a, reg_b, reg_a8, reg_b8;
  logic       carry, carry8;
  logic [7:0] rom [16];
  logic [7:0] rom_d, rom_d8;
  int total = 0, bad = 0;
  bit live = 1'b0;

  assign rom_d  = rom[rom_a];
  assign rom_d8 = rom[rom_a8];

  td4_core dut (.CLK(clk), .RST(rst), .EN(en), .IN(in_p), .ROM_A(rom_a), .ROM_D(rom_d),
                .OUT(out_p), .CARRY(carry), .REG_A(reg_a), .REG_B(reg_b));
  td4_core #(.RESET_PC(4'h8)) dut8 (.CLK(clk), .RST(rst), .EN(en), .IN(in_p), .ROM_A(rom_a8),
                .ROM_D(rom_d8), .OUT(out8), .CARRY(carry8), .REG_A(reg_a8), .REG_B(reg_b8));

  always #5 clk = ~clk;

  // Instruction-set model: interprets the program byte at the model's own PC
  logic [3:0] m_pc, m_a, m_b, m_out;
  logic       m_c;
  logic [3:0] m_op, m_im;
  int         m_sa, m_sb;
  assign m_op = rom[m_pc][7:4];
  assign m_im = rom[m_pc][3:0];
  assign m_sa = int'(m_a) + int'(m_im);
  assign m_sb = int'(m_b) + int'(m_im);

  always @(posedge clk) begin
    if (rst) begin
      m_pc <= 4'h0; m_a <= 4'h0; m_b <= 4'h0; m_c <= 1'b0; m_out <= 4'h0;
    end else if (en) begin
      m_c  <= 1'b0;
      m_pc <= 4'((int'(m_pc) + 1) % 16);
      case (m_op)
        4'h0: begin m_a <= 4'(m_sa % 16); m_c <= m_sa > 15; end
        4'h1: m_a <= m_b;
        4'h2: m_a <= in_p;
        4'h3: m_a <= m_im;
        4'h4: m_b <= m_a;
        4'h5: begin m_b <= 4'(m_sb % 16); m_c <= m_sb > 15; end
        4'h6: m_b <= in_p;
        4'h7: m_b <= m_im;
        4'h9: m_out <= m_b;
        4'hB: m_out <= m_im;
        4'hE: if (!m_c) m_pc <= m_im;
        4'hF: m_pc <= m_im;
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (live) begin
    chk("model ROM_A", rom_a, m_pc);
    chk("model REG_A", reg_a, m_a);
    chk("model REG_B", reg_b, m_b);
    chk("model CARRY", {3'b0, carry}, {3'b0, m_c});
    chk("model OUT", out_p, m_out);
  end

  task automatic step(input bit e);
    en = e;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    live = 1'b1;
  endtask

  task automatic load(input logic [7:0] p0, p1, p2, p3);
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    rom[0] = p0; rom[1] = p1; rom[2] = p2; rom[3] = p3;
  endtask

  initial begin
    // echo program with a reset-state check on both PC reset values
    load(8'h20, 8'h40, 8'h90, 8'hF0);
    in_p = 4'h9;
    do_reset();
    chk("reset ROM_A", rom_a, 4'h0);
    chk("reset OUT", out_p, 4'h0);
    chk("reset8 ROM_A", rom_a8, 4'h8);
    repeat (3) step(1);
    chk("echo OUT", out_p, 4'h9);
    chk("echo REG_B", reg_b, 4'h9);
    step(1);
    chk("echo wrap ROM_A", rom_a, 4'h0);
    in_p = 4'h3;
    repeat (4) step(1);
    chk("echo OUT 3", out_p, 4'h3);
    // EN gating mid-program, IN changed while stalled is ignored
    repeat (2) step(1);
    in_p = 4'hC;
    repeat (5) step(0);
    chk("gate ROM_A", rom_a, 4'h2);
    chk("gate REG_B", reg_b, 4'h3);
    chk("gate OUT", out_p, 4'h3);
    in_p = 4'h3;
    step(1);
    chk("gate resume ROM_A", rom_a, 4'h3);
    // carry, JNC not taken
    load(8'h3F, 8'h01, 8'hE5, 8'hF0);
    do_reset();
    repeat (2) step(1);
    chk("carry A", reg_a, 4'h0);
    chk("carry C", {3'b0, carry}, 4'h1);
    step(1);
    chk("jnc not taken ROM_A", rom_a, 4'h3);
    chk("jnc clears C", {3'b0, carry}, 4'h0);
    // carry clear, JNC taken
    load(8'h3F, 8'h00, 8'hE5, 8'hF0);
    do_reset();
    repeat (3) step(1);
    chk("jnc taken ROM_A", rom_a, 4'h5);
    // PC wrap over all NOPs
    load(8'h80, 8'h80, 8'h80, 8'h80);
    do_reset();
    repeat (15) step(1);
    chk("wrap ROM_A F", rom_a, 4'hF);
    step(1);
    chk("wrap ROM_A 0", rom_a, 4'h0);
    chk("wrap REG_A", reg_a, 4'h0);
    // reset priority while ADD A,1 with A=F is on ROM_D
    load(8'hB5, 8'h3F, 8'h01, 8'hF0);
    do_reset();
    repeat (2) step(1);
    chk("pre-reset OUT", out_p, 4'h5);
    chk("pre-reset A", reg_a, 4'hF);
    do_reset();
    chk("rst prio A", reg_a, 4'h0);
    chk("rst prio C", {3'b0, carry}, 4'h0);
    chk("rst prio OUT", out_p, 4'h0);
    chk("rst prio ROM_A", rom_a, 4'h0);
    chk("rst prio ROM_A8", rom_a8, 4'h8);
    // ADD B and OUT Im
    load(8'h77, 8'h5A, 8'hB5, 8'hF0);
    do_reset();
    step(1);
    chk("movb B", reg_b, 4'h7);
    step(1);
    chk("addb B", reg_b, 4'h1);
    chk("addb C", {3'b0, carry}, 4'h1);
    step(1);
    chk("outim OUT", out_p, 4'h5);
    chk("outim C", {3'b0, carry}, 4'h0);
    step(1);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/td4_core.md
# td4_core

Single-cycle TD4 execution core: holds the 4-bit program counter, registers A and B, the carry flag and the output port latch. It drives the address of the combinational 16×8 program ROM and consumes the instruction byte it returns. It decodes and executes one instruction per enabled clock edge. It sits directly downstream of the program memory and upstream of the board I/O (switch input, LED output).

## Interface
- RESET_PC, 4'h0, PC value loaded on reset.

- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high; overrides EN.
- EN  in  1  step enable; one instruction executes per rising edge with EN=1. EN=0 holds all state.
- IN  in  4  input port; sampled directly at the executing edge. Must already be synchronous to CLK.
- ROM_A  out  4  program memory address; equals PC (registered, no combinational path).
- ROM_D  in  8  instruction from program memory; combinational function of ROM_A. Bits [7:4] = opcode, bits [3:0] = Im.
- OUT  out  4  output port latch.
- CARRY  out  1  carry flag.
- REG_A  out  4  register A, for debug/LED.
- REG_B  out  4  register B, for debug/LED.

## Operation
- State: PC[3:0], A[3:0], B[3:0], C, OUT[3:0]. All outputs are direct register outputs.
- Each enabled edge executes the instruction on ROM_D, as listed below:
  - 0000 ADD A,Im: {C,A} ← A+Im (5-bit sum).
  - 0001 MOV A,B: A ← B.
  - 0010 IN A: A ← IN.
  - 0011 MOV A,Im: A ← Im.
  - 0100 MOV B,A: B ← A.
  - 0101 ADD B,Im: {C,B} ← B+Im.
  - 0110 IN B: B ← IN.
  - 0111 MOV B,Im: B ← Im.
  - 1001 OUT B: OUT ← B.
  - 1011 OUT Im: OUT ← Im.
  - 1110 JNC Im: PC ← Im if C==0 (C before this edge), else PC+1.
  - 1111 JMP Im: PC ← Im.
  - 1000, 1010, 1100, 1101: NOP.
- Carry rule: C is written on every executed instruction. ADD writes the carry-out. All other opcodes, including jumps and NOPs, write 0.
- PC rule: PC ← PC+1 mod 16 except on a taken jump. 4'hF+1 wraps to 4'h0.
- Registers not named by the instruction hold their value. OUT changes only on OUT B or OUT Im.
- Arithmetic is unsigned 4-bit with wrap-around; carry is bit 4 of the 5-bit sum.

## Timing
- Reset: on a rising edge with RST=1, PC←RESET_PC and A, B, C, OUT ← 0, regardless of EN. RST asserted mid-program aborts the instruction on ROM_D; nothing of it is committed.
- First instruction after reset executes on the first edge with RST=0 and EN=1, using ROM_D for address RESET_PC.
- Latency: one instruction per enabled edge; results are visible on outputs immediately after that edge.
- An instruction reading a register sees the value from before the edge, so MOV B,A after IN A gets the new A on the next instruction.
- EN=0: no state change. ROM_A is stable, so ROM_D may be observed without side effects.
- IN is sampled only at the executing edge. Changes at other times are ignored.
- No multi-cycle states; the only "state machine" is PC sequencing.

## Test plan
- Echo program, ROM = {0x20, 0x40, 0x90, 0xF0}, IN=4'h9 → after 3 enabled edges OUT=9, REG_B=9. The 4th edge gives ROM_A=0. IN changed to 4'h3 → OUT=3 after 4 more edges.
- Carry, ROM = {0x3F, 0x01, 0xE5, 0xF0 …}: MOV A,F then ADD A,1 gives A=0, C=1. JNC 5 is not taken, ROM_A=3, and C is cleared to 0. Repeat with 0x00 at addr 1: JNC is taken, ROM_A=5.
- PC wrap: 16 consecutive NOPs (0x80) from reset → ROM_A returns to 0 after 16 edges, and no register changes.
- EN gating: EN low for 5 edges mid-program → PC, A, B, C and OUT are unchanged. Resuming EN continues at the same ROM_A.
- Reset priority: RST=1 and EN=1 while executing ADD A,1 with A=F → A=0, C=0, OUT=0, ROM_A=RESET_PC. Repeat with RESET_PC=4'h8 → ROM_A=8.
- ADD B and OUT Im: MOV B,Im 0x7; ADD B,0xA → B=1, C=1; OUT Im 0x5 → OUT=5, C=0.
